// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
//
// Purpose
//   Single-outstanding APB (AMBA 3/4 style) initiator. Accepts one request on a
//   valid/ready request channel, runs it as an APB SETUP + ACCESS transfer, and
//   returns the result on a valid/ready response channel. An ACCESS phase that
//   never sees i_pready is forced to complete with an error after
//   TIMEOUT_CYCLES wait cycles.
//
// Handshake rules (both channels)
//   A transfer happens on a rising edge where valid && ready are both 1. Once
//   the sender raises valid, it keeps valid and its payload stable until that
//   edge. Ready may depend on internal state only, never on valid.
//
// Parameters
//   TIMEOUT_CYCLES  max ACCESS wait cycles before forced error (1..65535)
//
// Ports
//   i_clk, i_nrst        clock (rising edge), async active-low reset
//   i_req_*/o_req_ready  request channel: addr, write, wdata, wstrb
//   o_resp_*/i_resp_ready response channel: rdata, err (slave error or timeout)
//   o_p*/i_p*            APB initiator signals (o_pprot is constant 3'b000)
//   o_dbg_state          current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// -----------------------------------------------------------------------------
module apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_nrst,

    // request channel
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_write,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,

    // response channel
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,

    // APB initiator
    output logic [31:0] o_paddr,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_pwdata,
    output logic [3:0]  o_pstrb,
    output logic [2:0]  o_pprot,
    input  logic [31:0] i_prdata,
    input  logic        i_pready,
    input  logic        i_pslverr,

    // debug
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = TIMEOUT_CYCLES[15:0];

    state_t      state;
    logic [15:0] wait_cnt;    // ACCESS cycles seen with i_pready low
    logic [15:0] wait_cnt_nx;

    assign wait_cnt_nx = wait_cnt + 16'd1;
    assign o_pprot     = 3'b000;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= IDLE;
            wait_cnt     <= 16'd0;
            o_req_ready  <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_resp_err   <= 1'b0;
            o_paddr      <= 32'd0;
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_pwrite     <= 1'b0;
            o_pwdata     <= 32'd0;
            o_pstrb      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    // o_req_ready is low only for the first cycle after reset
                    // release; it comes up here and stays up while idle.
                    if (!o_req_ready) begin
                        o_req_ready <= 1'b1;
                    end else if (i_req_valid) begin
                        o_paddr     <= i_req_addr;
                        o_pwrite    <= i_req_write;
                        o_pwdata    <= i_req_wdata;
                        o_pstrb     <= i_req_write ? i_req_wstrb : 4'h0;
                        o_req_ready <= 1'b0;
                        o_psel      <= 1'b1;
                        o_penable   <= 1'b0;
                        wait_cnt    <= 16'd0;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    // APB slave inputs are not looked at here.
                    o_penable <= 1'b1;
                    wait_cnt  <= 16'd0;
                    state     <= ACCESS;
                end

                ACCESS: begin
                    // i_pready wins over the timeout when both land on one edge.
                    if (i_pready) begin
                        o_resp_rdata <= o_pwrite ? 32'd0 : i_prdata;
                        o_resp_err   <= i_pslverr;
                        o_psel       <= 1'b0;
                        o_penable    <= 1'b0;
                        o_resp_valid <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt_nx;
                        if (wait_cnt_nx == TIMEOUT_LIM) begin
                            o_resp_rdata <= 32'd0;
                            o_resp_err   <= 1'b1;
                            o_psel       <= 1'b0;
                            o_penable    <= 1'b0;
                            o_resp_valid <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end

                RESP: begin
                    // Response payload holds until the consumer takes it.
                    if (i_resp_ready) begin
                        o_resp_valid <= 1'b0;
                        o_req_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
module tb_apb_initiator;

  localparam int TMO = 4;

  // ---------------- DUT signals ----------------
  logic        i_clk;
  logic        i_nrst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_write;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wstrb;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic [31:0] o_paddr;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;
  logic [31:0] i_prdata;
  logic        i_pready;
  logic        i_pslverr;
  logic [1:0]  o_dbg_state;

  apb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_write(i_req_write),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwrite(o_pwrite), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .o_pprot(o_pprot), .i_prdata(i_prdata), .i_pready(i_pready),
    .i_pslverr(i_pslverr), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- types and scoreboard ----------------
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;   // ACCESS wait cycles before pready (>= TMO: never)
    logic [31:0] prdata;
    bit          slverr;
    int          stall;   // cycles resp_ready is held low
  } txn_t;

  typedef struct {
    txn_t        t;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_psel;
    int          exp_pen;
  } vec_t;

  logic [32:0] exp_q[$];   // {err, rdata}
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference model: outcome of a transaction from the protocol rules alone.
  function automatic void predict(input txn_t t, output logic [31:0] rdata,
                                  output bit err, output int psel_cyc, output int pen_cyc);
    bit timed_out;
    timed_out = (t.waits >= TMO);
    pen_cyc   = timed_out ? TMO : t.waits + 1;
    psel_cyc  = pen_cyc + 1;
    err       = timed_out ? 1'b1 : t.slverr;
    rdata     = (timed_out || t.write) ? 32'd0 : t.prdata;
  endfunction

  // ---------------- driver tasks ----------------
  // Runs one transaction starting at a negedge, acting as the APB slave and
  // response consumer. Keeps a junk request on the request channel while busy.
  task automatic run_txn(input txn_t t, output logic [31:0] got_rdata, output logic got_err,
                         output int psel_cyc, output int pen_cyc,
                         output bit fields_ok, output bit hold_ok, output bit done_ok);
    int guard;
    logic [3:0] exp_strb;
    exp_strb  = t.write ? t.wstrb : 4'h0;
    psel_cyc  = 0;
    pen_cyc   = 0;
    fields_ok = 1;
    hold_ok   = 1;
    done_ok   = 1;
    got_rdata = '0;
    got_err   = 1'b0;

    i_req_valid = 1'b1;
    i_req_addr  = t.addr;
    i_req_write = t.write;
    i_req_wdata = t.wdata;
    i_req_wstrb = t.wstrb;
    guard = 0;
    while (!o_req_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_req_ready) begin
      done_ok = 0;
      i_req_valid = 1'b0;
      return;
    end
    @(negedge i_clk);
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    i_req_write = ~t.write;
    i_req_wstrb = 4'($urandom);

    guard = 0;
    while (!o_resp_valid && guard < 20) begin
      if (o_psel) begin
        psel_cyc++;
        if (o_paddr !== t.addr || o_pwrite !== t.write || o_pwdata !== t.wdata ||
            o_pstrb !== exp_strb || o_pprot !== 3'b000)
          fields_ok = 0;
      end
      if (o_penable) begin
        pen_cyc++;
        i_pready  = (pen_cyc - 1 == t.waits);
        i_prdata  = i_pready ? t.prdata : $urandom;
        i_pslverr = i_pready ? t.slverr : 1'($urandom_range(0, 1));
      end else begin
        i_pready  = 1'($urandom_range(0, 1));
        i_prdata  = $urandom;
        i_pslverr = 1'($urandom_range(0, 1));
      end
      @(negedge i_clk);
      guard++;
    end
    if (!o_resp_valid) begin
      done_ok = 0;
      i_req_valid = 1'b0;
      i_pready = 1'b0;
      return;
    end
    got_rdata = o_resp_rdata;
    got_err   = o_resp_err;

    i_resp_ready = 1'b0;
    for (int s = 0; s < t.stall; s++) begin
      i_pready  = 1'($urandom_range(0, 1));
      i_prdata  = $urandom;
      i_pslverr = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      if (o_resp_valid !== 1'b1 || o_resp_rdata !== got_rdata || o_resp_err !== got_err ||
          o_req_ready !== 1'b0 || o_psel !== 1'b0)
        hold_ok = 0;
    end
    i_req_valid  = 1'b0;
    i_pready     = 1'b0;
    i_resp_ready = 1'b1;
    @(negedge i_clk);
    if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) hold_ok = 0;
    i_resp_ready = 1'b0;
  endtask

  task automatic check_txn(string tag, input txn_t t, input logic [31:0] exp_rdata,
                           input bit exp_err, input int exp_psel, input int exp_pen);
    logic [31:0] rd;
    logic er;
    int ps, pe;
    bit f_ok, h_ok, d_ok;
    run_txn(t, rd, er, ps, pe, f_ok, h_ok, d_ok);
    check({tag, "_done"},  64'(d_ok), 64'(1));
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rdata));
    check({tag, "_err"},   64'(er), 64'(exp_err));
    check({tag, "_psel"},  64'(ps), 64'(exp_psel));
    check({tag, "_pen"},   64'(pe), 64'(exp_pen));
    check({tag, "_apb"},   64'(f_ok), 64'(1));
    check({tag, "_hold"},  64'(h_ok), 64'(1));
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];

  initial begin
    txn_t t;
    logic [31:0] m_rdata;
    bit m_err;
    int m_ps, m_pe;
    logic [32:0] exp_word;
    logic [31:0] rd;
    logic er;
    int ps, pe;
    bit f_ok, h_ok, d_ok;
    int last, n_acc, n_resp, psel_bad, guard;
    bit spacing_ok, no_resp;

    //               write addr          wdata          strb  waits prdata         slv stall   exp_rdata      err psel pen
    vecs[0] = '{'{1, 32'h0000_0008, 32'hA5A5_0001, 4'hF, 0,  32'h0,         0,  0}, 32'h0,         0, 2, 1};
    vecs[1] = '{'{0, 32'h0000_0004, 32'h0,         4'h0, 3,  32'h0000_0123, 0,  0}, 32'h0000_0123, 0, 5, 4};
    vecs[2] = '{'{0, 32'h0000_0010, 32'h0,         4'h0, 1,  32'hDEAD_BEEF, 1,  5}, 32'hDEAD_BEEF, 1, 3, 2};
    vecs[3] = '{'{0, 32'h0000_0020, 32'h0,         4'h0, 99, 32'h0000_0055, 0,  0}, 32'h0,         1, 5, 4};
    vecs[4] = '{'{0, 32'h0000_0024, 32'h0,         4'h0, 3,  32'h0000_0077, 0,  0}, 32'h0000_0077, 0, 5, 4};
    vecs[5] = '{'{1, 32'h0000_0100, 32'h1234_5678, 4'h5, 2,  32'hFFFF_FFFF, 1,  1}, 32'h0,         1, 4, 3};
    vecs[6] = '{'{1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'h3, 7,  32'h0000_0001, 0,  2}, 32'h0,         1, 5, 4};
    vecs[7] = '{'{0, 32'h0000_0200, 32'h1111_2222, 4'hF, 0,  32'hFFFF_FFFF, 0,  0}, 32'hFFFF_FFFF, 0, 2, 1};

    i_nrst = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_write = 1'b0; i_req_wdata = '0; i_req_wstrb = '0;
    i_resp_ready = 1'b0; i_prdata = '0; i_pready = 1'b0; i_pslverr = 1'b0;

    // reset state
    repeat (2) @(negedge i_clk);
    check("rst_req_ready",  64'(o_req_ready), 64'(0));
    check("rst_psel",       64'(o_psel), 64'(0));
    check("rst_penable",    64'(o_penable), 64'(0));
    check("rst_resp_valid", 64'(o_resp_valid), 64'(0));
    check("rst_resp_data",  64'({o_resp_err, o_resp_rdata}), 64'(0));
    check("rst_apb_data",   64'({o_pwrite, o_pstrb, o_paddr}), 64'(0));
    check("rst_pwdata",     64'(o_pwdata), 64'(0));
    check("rst_pprot",      64'(o_pprot), 64'(0));
    check("rst_state",      64'(o_dbg_state), 64'(0));
    i_nrst = 1'b1;
    @(negedge i_clk);
    check("rel_req_ready",  64'(o_req_ready), 64'(1));

    // table-driven vectors
    for (int i = 0; i < 8; i++)
      check_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].exp_rdata, vecs[i].exp_err,
                vecs[i].exp_psel, vecs[i].exp_pen);

    // reset during ACCESS: outputs drop at once, transaction is abandoned
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h40; i_pready = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check("mid_state_access", 64'({o_dbg_state, o_psel, o_penable}), 64'({2'd2, 2'b11}));
    #2 i_nrst = 1'b0;
    #1;
    check("mid_rst_psel_pen", 64'({o_psel, o_penable}), 64'(0));
    check("mid_rst_resp_valid", 64'(o_resp_valid), 64'(0));
    check("mid_rst_req_ready", 64'(o_req_ready), 64'(0));
    @(negedge i_clk);
    i_nrst = 1'b1;
    i_pready = 1'b1; i_prdata = 32'hBAD0_BAD0;
    @(negedge i_clk);
    no_resp = 1;
    for (int c = 0; c < 6; c++) begin
      if (o_resp_valid !== 1'b0 || o_psel !== 1'b0 || o_req_ready !== 1'b1) no_resp = 0;
      @(negedge i_clk);
    end
    i_pready = 1'b0;
    check("mid_rst_abandoned", 64'(no_resp), 64'(1));
    t = '{1, 32'h0000_0044, 32'h0BAD_CAFE, 4'hC, 1, 32'h0, 0, 0};
    check_txn("post_rst", t, 32'h0, 0, 3, 2);

    // back-to-back requests, zero-wait slave, consumer always ready
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h80;
    i_pready = 1'b1; i_prdata = 32'h5; i_pslverr = 1'b0; i_resp_ready = 1'b1;
    last = -1; n_acc = 0; n_resp = 0; psel_bad = 0; spacing_ok = 1;
    for (int c = 0; c < 30; c++) begin
      if (o_req_ready) begin
        if (last >= 0 && c - last != 4) spacing_ok = 0;
        last = c;
        n_acc++;
      end
      if (o_psel && (o_req_ready || o_resp_valid)) psel_bad++;
      if (o_resp_valid) n_resp++;
      @(negedge i_clk);
    end
    i_req_valid = 1'b0;
    guard = 0;
    while (!o_req_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    i_pready = 1'b0; i_resp_ready = 1'b0;
    check("b2b_spacing", 64'(spacing_ok), 64'(1));
    check("b2b_accepts", 64'(n_acc), 64'(8));
    check("b2b_resps", 64'(n_resp), 64'(7));
    check("b2b_psel_idle_resp", 64'(psel_bad), 64'(0));
    check("b2b_drained", 64'(o_req_ready), 64'(1));

    // randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      t.write  = 1'($urandom_range(0, 1));
      t.addr   = {$urandom, 2'b00} >> 2 << 2;
      t.wdata  = $urandom;
      t.wstrb  = 4'($urandom);
      t.waits  = $urandom_range(0, 6);
      t.prdata = $urandom;
      t.slverr = 1'($urandom_range(0, 1));
      t.stall  = $urandom_range(0, 3);
      predict(t, m_rdata, m_err, m_ps, m_pe);
      exp_q.push_back({m_err, m_rdata});
      run_txn(t, rd, er, ps, pe, f_ok, h_ok, d_ok);
      exp_word = exp_q.pop_front();
      check($sformatf("rnd%0d_done", i), 64'(d_ok), 64'(1));
      check($sformatf("rnd%0d_resp", i), 64'({er, rd}), 64'(exp_word));
      check($sformatf("rnd%0d_cycles", i), 64'({ps, pe}), 64'({m_ps, m_pe}));
      check($sformatf("rnd%0d_apb", i), 64'({f_ok, h_ok}), 64'(2'b11));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
